// File: rtl/vec_image_load_sequencer.sv
// Streams a contiguous run of 8-pixel vectors from image memory to the vector register-file port.
// Latency: start edge -> CHECK -> first address -> vector valid after the next edge; 1 vector/cycle.
// Backpressure: vec_ready low with vec_valid high freezes vec_data, vec_index and mem_addr.
module vec_image_load_sequencer #(
    parameter int ADDR_W       = 16,
    parameter int LANES        = 8,
    parameter int IMAGE_WIDTH  = 96,
    parameter int IMAGE_HEIGHT = 96,
    parameter int CNT_W        = 12
) (
    input  logic                    CLK,
    input  logic                    RST_N,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [CNT_W-1:0]        num_vectors,
    output logic [ADDR_W-1:0]       mem_addr,
    input  logic [15:0][15:0]       mem_rd,
    output logic [15:0][15:0]       vec_data,
    output logic [CNT_W-1:0]        vec_index,
    output logic                    vec_valid,
    input  logic                    vec_ready,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    localparam int END_W  = ADDR_W + CNT_W + 3;
    localparam int PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam logic [END_W-1:0] PIXELS_E = END_W'(PIXELS);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CHECK  = 3'd1,
        RUN    = 3'd2,
        DRAIN  = 3'd3,
        FINISH = 3'd4
    } state_t;

    state_t                 state_q;
    logic [ADDR_W-1:0]      base_q;
    logic [CNT_W-1:0]       num_q;
    logic [ADDR_W-1:0]      cur_addr_q;
    logic [CNT_W-1:0]       remaining_q;
    logic [CNT_W-1:0]       issue_idx_q;
    logic [15:0][15:0]      vec_data_q;
    logic [CNT_W-1:0]       vec_index_q;
    logic                   vec_valid_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   err_q;

    logic [END_W-1:0]       end_addr;
    logic [15:0][15:0]      rd_masked;
    logic                   fetch;
    logic                   unused_rd_hi;

    // Full-width end address so a huge base or count can never wrap into range.
    assign end_addr = END_W'(base_q) + END_W'(num_q) * END_W'(LANES);

    always_comb begin
        rd_masked = '0;
        for (int l = 0; l < LANES; l++) begin
            rd_masked[l] = mem_rd[l];
        end
    end

    assign unused_rd_hi = ^mem_rd[15:LANES];

    assign fetch    = (state_q == RUN) && (!vec_valid_q || vec_ready) && (remaining_q != '0);
    assign mem_addr = (state_q == RUN) ? cur_addr_q : '0;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            base_q      <= '0;
            num_q       <= '0;
            cur_addr_q  <= '0;
            remaining_q <= '0;
            issue_idx_q <= '0;
            vec_data_q  <= '0;
            vec_index_q <= '0;
            vec_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        base_q  <= base_addr;
                        num_q   <= num_vectors;
                        busy_q  <= 1'b1;
                        state_q <= CHECK;
                    end
                end
                CHECK: begin
                    if (end_addr > PIXELS_E) begin
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (num_q == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= FINISH;
                    end else begin
                        cur_addr_q  <= base_q;
                        remaining_q <= num_q;
                        issue_idx_q <= '0;
                        state_q     <= RUN;
                    end
                end
                RUN: begin
                    if (fetch) begin
                        vec_data_q  <= rd_masked;
                        vec_index_q <= issue_idx_q;
                        vec_valid_q <= 1'b1;
                        cur_addr_q  <= cur_addr_q + ADDR_W'(LANES);
                        issue_idx_q <= issue_idx_q + CNT_W'(1);
                        remaining_q <= remaining_q - CNT_W'(1);
                        if (remaining_q == CNT_W'(1)) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The last vector is already registered; only its acceptance is pending.
                    if (vec_ready) begin
                        vec_valid_q <= 1'b0;
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= FINISH;
                    end
                end
                FINISH: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign vec_data  = vec_data_q;
    assign vec_index = vec_index_q;
    assign vec_valid = vec_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_vec_image_load_sequencer.sv
// Bench for vec_image_load_sequencer: vector table, exact-timing sequences and random jobs vs a reference model.
module tb_vec_image_load_sequencer;

    localparam int LANES  = 8;
    localparam int PIXELS = 96 * 96;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       base_addr = '0;
    logic [11:0]       num_vectors = '0;
    logic [15:0]       mem_addr;
    logic [15:0][15:0] mem_rd;
    logic [15:0][15:0] vec_data;
    logic [11:0]       vec_index;
    logic              vec_valid;
    logic              vec_ready = 1'b0;
    logic              busy;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    vec_image_load_sequencer dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .start       (start),
        .base_addr   (base_addr),
        .num_vectors (num_vectors),
        .mem_addr    (mem_addr),
        .mem_rd      (mem_rd),
        .vec_data    (vec_data),
        .vec_index   (vec_index),
        .vec_valid   (vec_valid),
        .vec_ready   (vec_ready),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    // Image content: every pixel address maps to a distinct-looking value, all 16 lanes populated.
    function automatic logic [15:0] pix(input int a);
        int unsigned h;
        h = a * 40503 + 12345;
        h = h ^ (h >> 7);
        return h[15:0];
    endfunction

    always_comb begin
        mem_rd = '0;
        for (int l = 0; l < 16; l++) mem_rd[l] = pix(int'(mem_addr) + l);
    end

    function automatic logic [255:0] exp_vec(input int base, input int k);
        logic [15:0][15:0] v;
        v = '0;
        for (int l = 0; l < LANES; l++) v[l] = pix(base + LANES * k + l);
        return v;
    endfunction

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    // Runs one command to completion, scoring every handshake against the model.
    // ready_mode: 0 always ready, 1 pattern 1,0,0, 2 random.
    task automatic run_job(input string tag, input int base, input int n, input int ready_mode,
                           input bit poke, input bit exp_err, input int exp_cnt);
        int got;
        int limit;
        bit saw_done, saw_err, stalled, any_valid;
        logic [255:0] held_dat;
        logic [11:0]  held_idx;
        logic [15:0]  held_addr;
        base_addr   = base[15:0];
        num_vectors = n[11:0];
        start = 1'b1;
        tick;
        start = 1'b0;
        base_addr   = 16'($urandom);
        num_vectors = 12'($urandom);
        got = 0; saw_done = 0; saw_err = 0; stalled = 0; any_valid = 0;
        held_dat = '0; held_idx = '0; held_addr = '0;
        limit = 4 * n + 40;
        for (int cyc = 0; cyc < limit && !saw_done && !saw_err; cyc++) begin
            case (ready_mode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = (cyc % 3 == 0);
                default: vec_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke) begin
                start = (cyc == 3);
                if (cyc == 3) begin
                    base_addr   = 16'd5000;
                    num_vectors = 12'd2;
                end
            end
            #1;
            if (stalled) begin
                chk({tag, "/stall_data"}, vec_data, held_dat);
                chk({tag, "/stall_idx"}, vec_index, held_idx);
                chk({tag, "/stall_addr"}, mem_addr, held_addr);
            end
            if (vec_valid) any_valid = 1;
            if (vec_valid && vec_ready) begin
                chk({tag, "/data"}, vec_data, exp_vec(base, got));
                chk({tag, "/index"}, vec_index, got[11:0]);
                got++;
            end
            stalled   = vec_valid && !vec_ready;
            held_dat  = vec_data;
            held_idx  = vec_index;
            held_addr = mem_addr;
            if (done) saw_done = 1;
            if (err)  saw_err = 1;
            if (!(saw_done || saw_err)) tick;
        end
        start = 1'b0;
        chk({tag, "/err"}, saw_err, exp_err);
        chk({tag, "/done"}, saw_done, !exp_err);
        chk({tag, "/count"}, got, exp_cnt);
        if (exp_err) chk({tag, "/no_valid"}, any_valid, 1'b0);
        vec_ready = 1'b0;
        tick;
        chk({tag, "/busy_after"}, busy, 1'b0);
        chk({tag, "/pulse_width"}, done | err, 1'b0);
        chk({tag, "/valid_after"}, vec_valid, 1'b0);
    endtask

    typedef struct {
        string name;
        int    base;
        int    n;
        int    ready_mode;
        bit    poke;
        bit    exp_err;
        int    exp_cnt;
    } vec_t;

    vec_t tbl[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl.push_back('{"b0n4_rdy",      0,     4,    0, 0, 0, 4});
        tbl.push_back('{"b0n4_toggle",   0,     4,    1, 0, 0, 4});
        tbl.push_back('{"top_ok",        9208,  1,    0, 0, 0, 1});
        tbl.push_back('{"top_over",      9210,  1,    0, 0, 1, 0});
        tbl.push_back('{"top2_ok",       9200,  2,    2, 0, 0, 2});
        tbl.push_back('{"top2_over",     9201,  2,    0, 0, 1, 0});
        tbl.push_back('{"whole_image",   0,     1152, 0, 0, 0, 1152});
        tbl.push_back('{"image_plus1",   0,     1153, 0, 0, 1, 0});
        tbl.push_back('{"wrap16",        65528, 1,    0, 0, 1, 0});
        tbl.push_back('{"max_both",      65535, 4095, 0, 0, 1, 0});
        tbl.push_back('{"zero_n",        300,   0,    0, 0, 0, 0});
        tbl.push_back('{"restart_poke",  100,   12,   1, 1, 0, 12});

        // Reset state, held in reset.
        tick; tick;
        chk("rst/mem_addr", mem_addr, 16'd0);
        chk("rst/vec_data", vec_data, 256'd0);
        chk("rst/vec_index", vec_index, 12'd0);
        chk("rst/vec_valid", vec_valid, 1'b0);
        chk("rst/busy", busy, 1'b0);
        chk("rst/done", done, 1'b0);
        chk("rst/err", err, 1'b0);
        RST_N = 1'b1;
        tick;

        // Exact timing: base 0, 4 vectors, always ready.
        vec_ready = 1'b1;
        base_addr = 16'd0; num_vectors = 12'd4; start = 1'b1;
        tick; start = 1'b0;
        chk("t1/check_busy", busy, 1'b1);
        chk("t1/check_valid", vec_valid, 1'b0);
        tick;
        chk("t1/addr0", mem_addr, 16'd0);
        chk("t1/valid_early", vec_valid, 1'b0);
        for (int k = 0; k < 4; k++) begin
            tick;
            chk($sformatf("t1/valid%0d", k), vec_valid, 1'b1);
            chk($sformatf("t1/index%0d", k), vec_index, 12'(k));
            chk($sformatf("t1/data%0d", k), vec_data, exp_vec(0, k));
            chk($sformatf("t1/addr%0d", k + 1), mem_addr, (k < 3) ? 16'(8 * (k + 1)) : 16'd0);
            chk($sformatf("t1/done_early%0d", k), done, 1'b0);
        end
        tick;
        chk("t1/done", done, 1'b1);
        chk("t1/busy_finish", busy, 1'b0);
        chk("t1/valid_finish", vec_valid, 1'b0);
        tick;
        chk("t1/done_off", done, 1'b0);

        // Exact timing: zero-length job finishes two cycles after start.
        base_addr = 16'd64; num_vectors = 12'd0; start = 1'b1;
        tick; start = 1'b0;
        chk("t0/c1_done", done, 1'b0);
        chk("t0/c1_busy", busy, 1'b1);
        tick;
        chk("t0/c2_done", done, 1'b1);
        chk("t0/c2_valid", vec_valid, 1'b0);
        tick;
        chk("t0/c3_done", done, 1'b0);
        vec_ready = 1'b0;

        foreach (tbl[i]) begin
            run_job(tbl[i].name, tbl[i].base, tbl[i].n, tbl[i].ready_mode,
                    tbl[i].poke, tbl[i].exp_err, tbl[i].exp_cnt);
        end

        // Asynchronous reset while a vector is stalled on the output.
        vec_ready = 1'b0;
        base_addr = 16'd40; num_vectors = 12'd10; start = 1'b1;
        tick; start = 1'b0;
        for (int c = 0; c < 10 && !vec_valid; c++) tick;
        chk("arst/pre_valid", vec_valid, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk("arst/vec_valid", vec_valid, 1'b0);
        chk("arst/vec_data", vec_data, 256'd0);
        chk("arst/vec_index", vec_index, 12'd0);
        chk("arst/mem_addr", mem_addr, 16'd0);
        chk("arst/busy", busy, 1'b0);
        chk("arst/done_err", done | err, 1'b0);
        tick;
        RST_N = 1'b1;
        tick;
        run_job("after_rst", 16, 3, 2, 0, 0, 3);

        // Random jobs against the range/ordering model.
        for (int r = 0; r < 25; r++) begin
            int b, n;
            bit e;
            b = (r % 4 == 0) ? $urandom_range(PIXELS - 200, PIXELS + 20) : $urandom_range(0, PIXELS);
            n = $urandom_range(0, 24);
            e = (b + LANES * n) > PIXELS;
            run_job($sformatf("rnd%0d", r), b, n, 2, 0, e, e ? 0 : n);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
